// File: rtl/register_window_spill_fill_if.sv
// ---------------------------------------------------------------------------
// register_window_spill_fill_if : request, register-file and memory bundle
// Rev 1.0 ; WINDOW_STATS_EN adds the spill/fill counters
// ---------------------------------------------------------------------------
`default_nettype none

interface register_window_spill_fill_if #(
  parameter int NWINDOWS = 8
);
  localparam int WW = $clog2(NWINDOWS);

  logic          save_i;
  logic          restore_i;
  logic [WW-1:0] cwp_o;
  logic          busy_o;
  logic          done_o;
  logic          trap_o;
  logic [WW-1:0] rf_win_o;
  logic [4:0]    rf_addr_o;
  logic [31:0]   rf_rdata_i;
  logic [31:0]   rf_wdata_o;
  logic          rf_we_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [31:0]   mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic          mem_ack_i;
  logic [31:0]   mem_rdata_i;
`ifdef WINDOW_STATS_EN
  logic [15:0]   spill_count_o;
  logic [15:0]   fill_count_o;

  modport slave (
    input  save_i, restore_i, rf_rdata_i, mem_ack_i, mem_rdata_i,
    output cwp_o, busy_o, done_o, trap_o, rf_win_o, rf_addr_o, rf_wdata_o,
           rf_we_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
           spill_count_o, fill_count_o
  );
  modport master (
    output save_i, restore_i, rf_rdata_i, mem_ack_i, mem_rdata_i,
    input  cwp_o, busy_o, done_o, trap_o, rf_win_o, rf_addr_o, rf_wdata_o,
           rf_we_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
           spill_count_o, fill_count_o
  );
`else
  modport slave (
    input  save_i, restore_i, rf_rdata_i, mem_ack_i, mem_rdata_i,
    output cwp_o, busy_o, done_o, trap_o, rf_win_o, rf_addr_o, rf_wdata_o,
           rf_we_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
  modport master (
    output save_i, restore_i, rf_rdata_i, mem_ack_i, mem_rdata_i,
    input  cwp_o, busy_o, done_o, trap_o, rf_win_o, rf_addr_o, rf_wdata_o,
           rf_we_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
`endif

endinterface

`default_nettype wire

// File: rtl/register_window_spill_fill.sv
// ---------------------------------------------------------------------------
// register_window_spill_fill : SPARC window pointer tracking with spill/fill
// Rev 1.0 ; optional macro WINDOW_STATS_EN adds spill/fill counters
// ---------------------------------------------------------------------------
`default_nettype none

module register_window_spill_fill #(
  parameter int          NWINDOWS   = 8,
  parameter logic [31:0] STACK_BASE = 32'h0000_8000,
  parameter logic [31:0] STACK_TOP  = 32'h0000_9000
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  register_window_spill_fill_if.slave bus
);

  localparam int          WW      = $clog2(NWINDOWS);
  localparam logic [WW-1:0] MAX_OCC = WW'(NWINDOWS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SPILL, S_FILL, S_FINISH} state_e;

  state_e        state_q;
  logic [WW-1:0] cwp_q;
  logic [WW-1:0] occ_q;
  logic [31:0]   sp_q;
  logic [3:0]    idx_q;
  logic          is_fill_q;
  logic          busy_q;
  logic          done_q;
  logic          trap_q;
  logic          req_q;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [WW-1:0] win_q;
  logic [4:0]    raddr_q;

  logic          w_ack;
  logic [31:0]   w_sp_inc;
  logic [31:0]   w_sp_dec;
  logic [WW-1:0] w_victim;

  // Acks only count while a request is actually outstanding
  assign w_ack    = bus.mem_ack_i & req_q;
  assign w_sp_inc = sp_q + 32'd64;
  assign w_sp_dec = sp_q - 32'd64;
  assign w_victim = cwp_q + occ_q - WW'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cwp_q     <= '0;
      occ_q     <= WW'(1);
      sp_q      <= STACK_BASE;
      idx_q     <= '0;
      is_fill_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      trap_q    <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      win_q     <= '0;
      raddr_q   <= '0;
    end else begin
      done_q <= 1'b0;
      trap_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.save_i && bus.restore_i) begin
            trap_q <= 1'b1;
          end else if (bus.save_i) begin
            if (occ_q != MAX_OCC) begin
              cwp_q  <= cwp_q - WW'(1);
              occ_q  <= occ_q + WW'(1);
              done_q <= 1'b1;
            end else if (w_sp_inc > STACK_TOP) begin
              trap_q <= 1'b1;
            end else begin
              state_q   <= S_SPILL;
              busy_q    <= 1'b1;
              req_q     <= 1'b1;
              we_q      <= 1'b1;
              addr_q    <= sp_q;
              win_q     <= w_victim;
              raddr_q   <= 5'd16;
              idx_q     <= '0;
              is_fill_q <= 1'b0;
            end
          end else if (bus.restore_i) begin
            if (occ_q != WW'(1)) begin
              cwp_q  <= cwp_q + WW'(1);
              occ_q  <= occ_q - WW'(1);
              done_q <= 1'b1;
            end else if (sp_q == STACK_BASE) begin
              trap_q <= 1'b1;
            end else begin
              state_q   <= S_FILL;
              busy_q    <= 1'b1;
              req_q     <= 1'b1;
              we_q      <= 1'b0;
              sp_q      <= w_sp_dec;
              addr_q    <= w_sp_dec;
              win_q     <= cwp_q + WW'(1);
              raddr_q   <= 5'd16;
              idx_q     <= '0;
              is_fill_q <= 1'b1;
            end
          end
        end
        S_SPILL, S_FILL: begin
          if (w_ack) begin
            if (idx_q == 4'd15) begin
              state_q <= S_FINISH;
              done_q  <= 1'b1;
              req_q   <= 1'b0;
              we_q    <= 1'b0;
              addr_q  <= '0;
              win_q   <= '0;
              raddr_q <= '0;
              if (is_fill_q) begin
                cwp_q <= cwp_q + WW'(1);
              end else begin
                cwp_q <= cwp_q - WW'(1);
                sp_q  <= w_sp_inc;
              end
            end else begin
              idx_q   <= idx_q + 4'd1;
              addr_q  <= addr_q + 32'd4;
              raddr_q <= raddr_q + 5'd1;
            end
          end
        end
        S_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cwp_o       = cwp_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.trap_o      = trap_q;
  assign bus.rf_win_o    = win_q;
  assign bus.rf_addr_o   = raddr_q;
  assign bus.mem_req_o   = req_q;
  assign bus.mem_we_o    = we_q;
  assign bus.mem_addr_o  = addr_q;
  // Spill data is taken straight off the combinational register-file read
  assign bus.mem_wdata_o = we_q ? bus.rf_rdata_i : 32'd0;
  assign bus.rf_we_o     = (state_q == S_FILL) & w_ack;
  assign bus.rf_wdata_o  = bus.rf_we_o ? bus.mem_rdata_i : 32'd0;

`ifdef WINDOW_STATS_EN
  logic [15:0] spill_cnt_q;
  logic [15:0] fill_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      spill_cnt_q <= '0;
      fill_cnt_q  <= '0;
    end else if (state_q == S_FINISH) begin
      if (is_fill_q) begin
        if (fill_cnt_q != 16'hFFFF) fill_cnt_q <= fill_cnt_q + 16'd1;
      end else begin
        if (spill_cnt_q != 16'hFFFF) spill_cnt_q <= spill_cnt_q + 16'd1;
      end
    end
  end

  assign bus.spill_count_o = spill_cnt_q;
  assign bus.fill_count_o  = fill_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_register_window_spill_fill.sv
// ---------------------------------------------------------------------------
// tb_register_window_spill_fill : scoreboard bench with window/stack model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_register_window_spill_fill;

  localparam int          NW   = 8;
  localparam logic [31:0] BASE = 32'h0000_8000;
  localparam logic [31:0] TOP  = 32'h0000_80C0;  // room for three spilled windows

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  register_window_spill_fill_if #(.NWINDOWS(NW)) bus ();

  register_window_spill_fill #(
    .NWINDOWS  (NW),
    .STACK_BASE(BASE),
    .STACK_TOP (TOP)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  logic [31:0] rf [NW][32];
  logic [31:0] mem [logic [31:0]];
  assign bus.rf_rdata_i = rf[bus.rf_win_o][bus.rf_addr_o];

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
    int          win;
    int          raddr;
  } beat_t;

  typedef struct {
    bit trap;
    int cwp;
    int cyc;
  } evt_t;

  beat_t       beat_q [$];
  evt_t        evt_q  [$];
  logic [31:0] stk    [$];
  int m_cwp, m_occ, m_spills, m_fills;
  int n_pass, n_total;
  int cyc, beats_acked, busy_cnt, ack_mode;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic int next_delay();
    if (ack_mode == 0) return 0;
    if (ack_mode == 1) return 2;
    return int'($urandom % 4);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: variable ack latency, stray acks while idle
  initial begin
    int wait_n;
    int tgt;
    wait_n = 0;
    tgt    = 0;
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = 32'd0;
    forever begin
      @(posedge clk); #1;
      if (bus.mem_req_o) begin
        if (wait_n >= tgt) begin
          bus.mem_ack_i   = 1'b1;
          bus.mem_rdata_i = mem.exists(bus.mem_addr_o) ? mem[bus.mem_addr_o] : $urandom;
          wait_n = 0;
          tgt    = next_delay();
        end else begin
          bus.mem_ack_i   = 1'b0;
          bus.mem_rdata_i = $urandom;
          wait_n++;
        end
      end else begin
        bus.mem_ack_i   = ($urandom % 2) == 1;
        bus.mem_rdata_i = $urandom;
        wait_n = 0;
        tgt    = next_delay();
      end
    end
  end

  // Monitor: pops expected beats and completion events
  always @(negedge clk) begin
    beat_t b;
    evt_t  e;
    if (!rst) begin
      if (bus.busy_o) busy_cnt++;
      if (bus.mem_req_o && bus.mem_ack_i) begin
        beats_acked++;
        if (beat_q.size() == 0) begin
          chk("unexpected_beat", 32'd1, 32'd0);
        end else begin
          b = beat_q.pop_front();
          chk("beat_we", {31'd0, bus.mem_we_o}, {31'd0, b.we});
          chk("beat_addr", bus.mem_addr_o, b.addr);
          chk("beat_rf_win", 32'(bus.rf_win_o), 32'(b.win));
          chk("beat_rf_addr", 32'(bus.rf_addr_o), 32'(b.raddr));
          if (b.we) begin
            chk("spill_wdata", bus.mem_wdata_o, b.data);
            mem[bus.mem_addr_o] = bus.mem_wdata_o;
          end else begin
            chk("fill_rf_we", {31'd0, bus.rf_we_o}, 32'd1);
            chk("fill_rf_wdata", bus.rf_wdata_o, b.data);
            rf[bus.rf_win_o][bus.rf_addr_o] = bus.rf_wdata_o;
          end
        end
      end
      if (bus.rf_we_o && !(bus.mem_req_o && bus.mem_ack_i && !bus.mem_we_o))
        chk("rf_we_context", 32'd0, 32'd1);
      if (bus.done_o || bus.trap_o) begin
        if (evt_q.size() == 0) begin
          chk("unexpected_event", {30'd0, bus.trap_o, bus.done_o}, 32'd0);
        end else begin
          e = evt_q.pop_front();
          chk("event_kind", {30'd0, bus.trap_o, bus.done_o}, e.trap ? 32'd2 : 32'd1);
          chk("event_cwp", 32'(bus.cwp_o), 32'(e.cwp));
          if (e.cyc >= 0) chk("event_latency", 32'(cyc - e.cyc), 32'd1);
        end
      end
    end
  end

  // Reference: resident windows plus a word stack whose depth sets the pointer
  task automatic predict(bit s, bit r);
    evt_t  e;
    beat_t b;
    int    v;
    int    base;
    e.cyc  = cyc;
    e.trap = 1'b0;
    if (s && r) begin
      e.trap = 1'b1;
    end else if (s) begin
      if (m_occ < NW - 1) begin
        m_cwp = (m_cwp + NW - 1) % NW;
        m_occ++;
      end else if (BASE + 32'(4 * stk.size()) + 32'd64 > TOP) begin
        e.trap = 1'b1;
      end else begin
        v = (m_cwp + m_occ - 1) % NW;
        for (int i = 0; i < 16; i++) begin
          b.we    = 1'b1;
          b.addr  = BASE + 32'(4 * stk.size());
          b.data  = rf[v][16 + i];
          b.win   = v;
          b.raddr = 16 + i;
          beat_q.push_back(b);
          stk.push_back(b.data);
        end
        m_cwp = (m_cwp + NW - 1) % NW;
        m_spills++;
        e.cyc = -1;
      end
    end else if (r) begin
      if (m_occ > 1) begin
        m_cwp = (m_cwp + 1) % NW;
        m_occ--;
      end else if (stk.size() == 0) begin
        e.trap = 1'b1;
      end else begin
        base = stk.size() - 16;
        for (int i = 0; i < 16; i++) begin
          b.we    = 1'b0;
          b.addr  = BASE + 32'(4 * (base + i));
          b.data  = stk[base + i];
          b.win   = (m_cwp + 1) % NW;
          b.raddr = 16 + i;
          beat_q.push_back(b);
        end
        for (int i = 0; i < 16; i++) void'(stk.pop_back());
        m_cwp = (m_cwp + 1) % NW;
        m_fills++;
        e.cyc = -1;
      end
    end
    e.cwp = m_cwp;
    evt_q.push_back(e);
  endtask

  task automatic pulse(bit s, bit r);
    bus.save_i    = s;
    bus.restore_i = r;
    @(posedge clk); #1;
    bus.save_i    = 1'b0;
    bus.restore_i = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((evt_q.size() != 0 || bus.busy_o) && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 500) begin
      chk("idle_timeout", 32'd0, 32'd1);
      evt_q.delete();
      beat_q.delete();
    end
  endtask

  task automatic issue(bit s, bit r);
    predict(s, r);
    pulse(s, r);
    wait_idle();
  endtask

  task automatic apply_reset();
    bus.save_i    = 1'b0;
    bus.restore_i = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    beat_q.delete();
    evt_q.delete();
    stk.delete();
    m_cwp = 0; m_occ = 1; m_spills = 0; m_fills = 0;
    chk("rst_mem_req", {31'd0, bus.mem_req_o}, 32'd0);
    chk("rst_cwp", 32'(bus.cwp_o), 32'd0);
    chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    chk("rst_done", {31'd0, bus.done_o}, 32'd0);
    chk("rst_trap", {31'd0, bus.trap_o}, 32'd0);
    chk("rst_mem_we", {31'd0, bus.mem_we_o}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr_o, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata_o, 32'd0);
    chk("rst_rf_we", {31'd0, bus.rf_we_o}, 32'd0);
    chk("rst_rf_win", 32'(bus.rf_win_o), 32'd0);
    chk("rst_rf_addr", 32'(bus.rf_addr_o), 32'd0);
`ifdef WINDOW_STATS_EN
    chk("rst_spill_count", 32'(bus.spill_count_o), 32'd0);
    chk("rst_fill_count", 32'(bus.fill_count_o), 32'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int k;
    int guard;
    bit s;
    bit r;
    n_pass = 0; n_total = 0; cyc = 0; beats_acked = 0; busy_cnt = 0; ack_mode = 0;
    bus.save_i = 1'b0;
    bus.restore_i = 1'b0;
    for (int w = 0; w < NW; w++)
      for (int a = 0; a < 32; a++) rf[w][a] = $urandom;

    @(posedge clk); #1;
    apply_reset();

    // Six plain saves, then the seventh spills window 0 with acks every cycle
    for (int n = 0; n < 6; n++) begin
      issue(1'b1, 1'b0);
      repeat (2) begin @(posedge clk); #1; end
    end
    chk("cwp_after_6_saves", 32'(bus.cwp_o), 32'd2);
    chk("busy_after_6_saves", {31'd0, bus.busy_o}, 32'd0);
    busy_cnt = 0;
    issue(1'b1, 1'b0);
    chk("spill_busy_cycles", 32'(busy_cnt), 32'd17);
    chk("cwp_after_spill", 32'(bus.cwp_o), 32'd1);

    // Six restores, then the seventh fills back
    for (int n = 0; n < 7; n++) issue(1'b0, 1'b1);
    chk("cwp_after_fill", 32'(bus.cwp_o), 32'd0);

    apply_reset();
    issue(1'b0, 1'b1);
    issue(1'b1, 1'b1);
    chk("cwp_after_traps", 32'(bus.cwp_o), 32'd0);

    // Fill the stack to its top; a restore during a spill must be ignored
    ack_mode = 1;
    for (int n = 0; n < 8; n++) issue(1'b1, 1'b0);
    predict(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    pulse(1'b0, 1'b1);
    wait_idle();
    issue(1'b1, 1'b0);
    chk("stack_depth_words", 32'(stk.size()), 32'd48);

    // Reset during the fifth beat of a slow spill
    apply_reset();
    for (int n = 0; n < 6; n++) issue(1'b1, 1'b0);
    predict(1'b1, 1'b0);
    beats_acked = 0;
    pulse(1'b1, 1'b0);
    guard = 0;
    while (beats_acked < 4 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("reached_fifth_beat", 32'(beats_acked), 32'd4);
    apply_reset();

    // Randomized mix
    ack_mode = 2;
    for (int n = 0; n < 150; n++) begin
      k = int'($urandom % 10);
      s = (k < 5) || (k == 9);
      r = (k >= 5);
      issue(s, r);
      if ($urandom % 3 == 0) begin @(posedge clk); #1; end
    end
    chk("final_cwp", 32'(bus.cwp_o), 32'(m_cwp));
`ifdef WINDOW_STATS_EN
    chk("spill_count", 32'(bus.spill_count_o), 32'(m_spills));
    chk("fill_count", 32'(bus.fill_count_o), 32'(m_fills));
`endif
    chk("no_pending_beats", 32'(beat_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
